rgb_led_sequencer: RTL and testbench
====================================

Name: rgb_led_sequencer

Overview:
- Controller for the iCE40 SB_RGBA_DRV LED driver.
- Sequences the driver power-up: CURREN first, then RGBLEDEN after a settling delay.
- Generates the three PWM inputs from a colour plus a mode (off, solid, blink, breathe).
- Accepts new settings over a valid/ready config handshake. Top level wires pwm_b to RGB0PWM, pwm_r to RGB1PWM, pwm_g to RGB2PWM.

Parameters:
TICK_DIV, 48000, clk cycles per pattern tick (1 ms at 48 MHz); must be >= 1
POWERUP_CYCLES, 1024, clk cycles CURREN is held before RGBLEDEN asserts; must be >= 1

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
cfg_valid  input  1  config request
cfg_ready  output  1  config can be accepted this cycle
cfg_mode  input  2  0 OFF, 1 SOLID, 2 BLINK, 3 BREATHE
cfg_color  input  24  {red[23:16], green[15:8], blue[7:0]} duty values
cfg_period  input  8  ticks per blink half-period / per breathe step; 0 treated as 1
curren  output  1  to SB_RGBA_DRV CURREN
rgbleden  output  1  to SB_RGBA_DRV RGBLEDEN
pwm_r  output  1  red PWM
pwm_g  output  1  green PWM
pwm_b  output  1  blue PWM

Behaviour:
- Reset (async, active-high):
  - All outputs 0 except cfg_ready = 1.
  - FSM = S_OFF; mode = OFF; all counters, duties, phase and level cleared.
- Transfer occurs on the clk edge where cfg_valid && cfg_ready. At that edge, mode/colour/period are latched and the following are reset: tick divider, step counter, blink phase (to 1 = on), breathe level (to 0, direction up).
- FSM states:
  - S_OFF: curren = 0, rgbleden = 0, cfg_ready = 1.
    - Non-OFF transfer -> S_POWERUP with power-up counter = 0.
    - OFF transfer -> stays in S_OFF (no-op).
  - S_POWERUP: curren = 1, rgbleden = 0, cfg_ready = 0.
    - Counter increments each cycle; after POWERUP_CYCLES cycles in this state -> S_RUN.
    - rgbleden rises on the cycle after the last S_POWERUP cycle.
  - S_RUN: curren = 1, rgbleden = 1, cfg_ready = 1.
    - Non-OFF transfer: stays in S_RUN; new settings are applied with no power-up repeat.
    - OFF transfer -> S_OFF: rgbleden and pwm_* drop on the next edge, and curren drops on that same edge.
- Tick divider: counts 0..TICK_DIV-1 in S_RUN only; a 1-cycle tick pulse fires at TICK_DIV-1, then the divider wraps to 0.
- Step counter: counts ticks; an "event" fires when it reaches max(cfg_period,1), then it clears.
- Target duty per channel c, by mode:
  - SOLID: color_c.
  - BLINK: color_c when phase = 1, else 0. Phase toggles on each event.
  - BREATHE: (color_c * (level+1)) >> 8, an 8-bit result.
    - Level steps by 1 per event. Going up, it reverses at 255; going down, it reverses at 0.
    - Sequence: 0,1..255,254..0,1...; no hold at either end.
- PWM:
  - 8-bit free-running counter pwm_cnt runs in all states and wraps 255 -> 0.
  - Active duties load from target duties only at the edge where pwm_cnt == 255, so there are no mid-period glitches.
  - pwm_c is a registered output equal to (pwm_cnt < duty_c) && (state == S_RUN).
  - Duty 0 gives constant low; duty 255 gives high for 255 of 256 cycles.
- Simultaneous events:
  - A transfer in the same cycle as a tick or event: the transfer wins and all pattern counters reset.
  - A transfer in the same cycle as duty reload: the reload uses the pre-transfer target.
- cfg_ready depends only on state (no combinational path from cfg_valid).
- Reset mid-operation (any state): outputs clear immediately, regardless of clk.

Test Plan:
- TICK_DIV=4, POWERUP_CYCLES=8; reset, then transfer SOLID colour 0x80_00_FF -> curren=1 at the next edge. cfg_ready=0 for 8 cycles, then rgbleden=1. After the next pwm wrap: pwm_r high 128/256 cycles, pwm_g never, pwm_b 255/256.
- BLINK, colour 0xFF0000, period 2 -> pwm_r active for 8 clk-ticks' worth (2 ticks x 4 clk), then zero for 2 ticks, repeating. Check the phase toggles exactly every 8 clocks; duty changes only take effect at pwm_cnt wrap.
- BREATHE, colour 0x000100? no: colour 0x0000FF, period 0 (treated 1) -> level rises one per tick, reaching 255 after 255 ticks, then falls. Sampled duty_b = level at 255, 0 at level 0.
- In S_RUN, transfer OFF -> one edge later rgbleden=0, curren=0, pwm_*=0, cfg_ready=1. A second OFF transfer produces no output change.
- Hold cfg_valid high during S_POWERUP with a different colour -> no transfer until cfg_ready=1. That colour is then accepted in the first S_RUN cycle and the pattern counters reset.
- Assert rst asynchronously mid-BLINK between clk edges -> all outputs 0 and cfg_ready=1 before the next edge. After release, the FSM remains in S_OFF.

Source files
------------

// File: rtl/rgb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rgb_led_sequencer
// Purpose  : Power-up sequencing and PWM pattern generation (off / solid /
//            blink / breathe) for the iCE40 SB_RGBA_DRV LED driver.
//            Connect pwm_b -> RGB0PWM, pwm_r -> RGB1PWM, pwm_g -> RGB2PWM.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_led_sequencer #(
  parameter int TICK_DIV       = 48000,
  parameter int POWERUP_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_mode,
  input  logic [23:0] cfg_color,
  input  logic [7:0]  cfg_period,
  output logic        curren,
  output logic        rgbleden,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b
);

  localparam int c_DIV_W = $clog2(TICK_DIV + 1);
  localparam int c_PU_W  = $clog2(POWERUP_CYCLES + 1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
  localparam logic [c_PU_W-1:0]  c_PU_LAST  = c_PU_W'(POWERUP_CYCLES - 1);

  localparam logic [1:0] c_MODE_OFF     = 2'd0;
  localparam logic [1:0] c_MODE_SOLID   = 2'd1;
  localparam logic [1:0] c_MODE_BLINK   = 2'd2;
  localparam logic [1:0] c_MODE_BREATHE = 2'd3;

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_POWERUP = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_PU_W-1:0]   r_pu_cnt;

  // Latched configuration; colour index 2 = red, 1 = green, 0 = blue
  logic [1:0]          r_mode;
  logic [2:0][7:0]     r_color;
  logic [7:0]          r_period;

  // Pattern timing
  logic [c_DIV_W-1:0]  r_div;
  logic [7:0]          r_step;
  logic                r_phase;
  logic [7:0]          r_level;
  logic                r_dir_down;

  // PWM
  logic [7:0]          r_pwm_cnt;
  logic [2:0][7:0]     r_duty;
  logic [2:0][7:0]     w_target;
  logic [2:0]          r_pwm;

  logic                w_xfer;
  logic                w_tick;
  logic                w_event;
  logic [7:0]          w_period_eff;

  // Readiness is a pure function of state so cfg_valid never loops back
  assign cfg_ready    = (r_state != S_POWERUP);
  assign w_xfer       = cfg_valid && cfg_ready;
  assign w_period_eff = (r_period == 8'd0) ? 8'd1 : r_period;
  assign w_tick       = (r_state == S_RUN) && (r_div == c_DIV_LAST);
  assign w_event      = w_tick && (r_step == (w_period_eff - 8'd1));

  assign pwm_r = r_pwm[2];
  assign pwm_g = r_pwm[1];
  assign pwm_b = r_pwm[0];

  // State register and power-up settling counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_OFF;
      r_pu_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_OFF) begin
        r_pu_cnt <= '0;
      end else if (r_state == S_POWERUP) begin
        r_pu_cnt <= r_pu_cnt + c_PU_W'(1);
      end
    end
  end

  // Next-state decode and driver enables
  always_comb begin
    w_state_next = r_state;
    curren       = 1'b0;
    rgbleden     = 1'b0;
    case (r_state)
      S_OFF: begin
        if (w_xfer && (cfg_mode != c_MODE_OFF)) begin
          w_state_next = S_POWERUP;
        end
      end
      S_POWERUP: begin
        curren = 1'b1;
        if (r_pu_cnt == c_PU_LAST) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        curren   = 1'b1;
        rgbleden = 1'b1;
        if (w_xfer && (cfg_mode == c_MODE_OFF)) begin
          w_state_next = S_OFF;
        end
      end
      default: w_state_next = S_OFF;
    endcase
  end

  // Configuration capture on an accepted handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= c_MODE_OFF;
      r_color  <= '0;
      r_period <= '0;
    end else if (w_xfer) begin
      r_mode   <= cfg_mode;
      r_color  <= cfg_color;
      r_period <= cfg_period;
    end
  end

  // Tick divider and step counter; a transfer restarts the pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_step <= '0;
    end else begin
      if (w_xfer || (r_state != S_RUN) || w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + c_DIV_W'(1);
      end
      if (w_xfer || w_event) begin
        r_step <= '0;
      end else if (w_tick) begin
        r_step <= r_step + 8'd1;
      end
    end
  end

  // Blink phase and triangular breathe level, both advanced per event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= 1'b0;
      r_level    <= '0;
      r_dir_down <= 1'b0;
    end else if (w_xfer) begin
      r_phase    <= 1'b1;
      r_level    <= '0;
      r_dir_down <= 1'b0;
    end else if (w_event) begin
      r_phase <= ~r_phase;
      if (!r_dir_down) begin
        if (r_level == 8'hFF) begin
          r_dir_down <= 1'b1;
          r_level    <= 8'hFE;
        end else begin
          r_level <= r_level + 8'd1;
        end
      end else begin
        if (r_level == 8'h00) begin
          r_dir_down <= 1'b0;
          r_level    <= 8'h01;
        end else begin
          r_level <= r_level - 8'd1;
        end
      end
    end
  end

  // Target duty per channel from mode, colour, phase and level
  always_comb begin
    w_target = '0;
    for (int c = 0; c < 3; c++) begin
      case (r_mode)
        c_MODE_SOLID:   w_target[c] = r_color[c];
        c_MODE_BLINK:   w_target[c] = r_phase ? r_color[c] : 8'd0;
        c_MODE_BREATHE: w_target[c] =
          8'((16'(r_color[c]) * (16'(r_level) + 16'd1)) >> 8);
        default:        w_target[c] = 8'd0;
      endcase
    end
  end

  // Free-running PWM counter; duties reload only at the period boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      if (r_pwm_cnt == 8'hFF) begin
        r_duty <= w_target;
      end
    end
  end

  // Registered PWM outputs, gated so they fall with rgbleden on shutdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        r_pwm[c] <= (r_pwm_cnt < r_duty[c]) && (w_state_next == S_RUN);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_led_sequencer
// Purpose  : Directed, scoreboard-checked bench for rgb_led_sequencer using a
//            cycle-level behavioural model built from closed-form patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_led_sequencer;

  localparam int TDIV = 4;
  localparam int PUC  = 8;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [23:0] cfg_color;
  logic [7:0]  cfg_period;
  logic        curren;
  logic        rgbleden;
  logic        pwm_r;
  logic        pwm_g;
  logic        pwm_b;

  rgb_led_sequencer #(
    .TICK_DIV       (TDIV),
    .POWERUP_CYCLES (PUC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_color  (cfg_color),
    .cfg_period (cfg_period),
    .curren     (curren),
    .rgbleden   (rgbleden),
    .pwm_r      (pwm_r),
    .pwm_g      (pwm_g),
    .pwm_b      (pwm_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  // Behavioural model state (0 OFF, 1 POWERUP, 2 RUN)
  int          m_state;
  int          m_pu;
  int          m_cnt;
  int          m_duty[3];
  int          m_mode;
  logic [23:0] m_color;
  int          m_period;
  int          m_k;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t item;
    item.tag = tag;
    item.exp = exp;
    sb_q.push_back(item);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_t item;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d with no expected entry", obs);
      return;
    end
    item = sb_q.pop_front();
    assert (obs === item.exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", item.tag, obs, item.exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_pu     = 0;
    m_cnt    = 0;
    for (int c = 0; c < 3; c++) m_duty[c] = 0;
    m_mode   = 0;
    m_color  = '0;
    m_period = 0;
    m_k      = 0;
    sb_q.delete();
  endtask

  // Target duty of channel c (2 red, 1 green, 0 blue) for the current cycle
  function automatic int m_target(input int c);
    int col;
    int p;
    int n;
    int f;
    col = int'(m_color[c*8 +: 8]);
    p   = (m_period == 0) ? 1 : m_period;
    n   = m_k / (TDIV * p);
    case (m_mode)
      1: return col;
      2: return ((n % 2) == 0) ? col : 0;
      3: begin
        f = n % 510;
        if (f > 255) f = 510 - f;
        return (col * (f + 1)) / 256;
      end
      default: return 0;
    endcase
  endfunction

  // One clock: predict every output, advance the model, then compare
  task automatic step();
    int t[3];
    int nxt;
    bit xfer;
    xfer = (cfg_valid === 1'b1) && (m_state != 1);
    for (int c = 0; c < 3; c++) t[c] = m_target(c);
    nxt = m_state;
    case (m_state)
      0: if (xfer && cfg_mode != 2'd0) nxt = 1;
      1: if (m_pu == PUC - 1) nxt = 2;
      2: if (xfer && cfg_mode == 2'd0) nxt = 0;
      default: nxt = 0;
    endcase
    push("pwm_r", 32'((m_cnt < m_duty[2]) && (nxt == 2)));
    push("pwm_g", 32'((m_cnt < m_duty[1]) && (nxt == 2)));
    push("pwm_b", 32'((m_cnt < m_duty[0]) && (nxt == 2)));
    if (m_cnt == 255) begin
      for (int c = 0; c < 3; c++) m_duty[c] = t[c];
    end
    m_cnt = (m_cnt + 1) % 256;
    if (m_state == 0 && nxt == 1) m_pu = 0;
    else if (m_state == 1)        m_pu = m_pu + 1;
    if (xfer) begin
      m_k      = 0;
      m_mode   = int'(cfg_mode);
      m_color  = cfg_color;
      m_period = int'(cfg_period);
    end else if (m_state == 2) begin
      m_k = m_k + 1;
    end
    m_state = nxt;
    push("curren",    32'(nxt != 0));
    push("rgbleden",  32'(nxt == 2));
    push("cfg_ready", 32'(nxt != 1));
    @(posedge clk);
    #1;
    pop_check(32'(pwm_r));
    pop_check(32'(pwm_g));
    pop_check(32'(pwm_b));
    pop_check(32'(curren));
    pop_check(32'(rgbleden));
    pop_check(32'(cfg_ready));
  endtask

  task automatic send(input int mode, input logic [23:0] color, input int period);
    cfg_valid  = 1'b1;
    cfg_mode   = 2'(mode);
    cfg_color  = color;
    cfg_period = 8'(period);
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    push("rst_pwm_r", 0);
    push("rst_pwm_g", 0);
    push("rst_pwm_b", 0);
    push("rst_curren", 0);
    push("rst_rgbleden", 0);
    push("rst_cfg_ready", 1);
    pop_check(32'(pwm_r));
    pop_check(32'(pwm_g));
    pop_check(32'(pwm_b));
    pop_check(32'(curren));
    pop_check(32'(rgbleden));
    pop_check(32'(cfg_ready));
  endtask

  initial begin
    int lowc;
    int guard;
    int cr;
    int cg;
    int cb;
    logic was_ready;

    cfg_valid  = 1'b0;
    cfg_mode   = 2'd0;
    cfg_color  = '0;
    cfg_period = '0;
    rst        = 1'b0;
    model_reset();

    // Power-on reset applied between clock edges
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // SOLID 0x8000FF: power-up length, then steady duty counts
    send(1, 24'h8000FF, 1);
    lowc  = 0;
    guard = 0;
    while (cfg_ready !== 1'b1 && guard < 50) begin
      lowc++;
      guard++;
      step();
    end
    push("powerup_ready_low_cycles", 32'(PUC));
    pop_check(32'(lowc));
    push("rgbleden_after_powerup", 1);
    pop_check(32'(rgbleden));
    repeat (512) step();
    cr = 0;
    cg = 0;
    cb = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      cr += int'(pwm_r);
      cg += int'(pwm_g);
      cb += int'(pwm_b);
    end
    push("solid_r_high_count", 128);
    pop_check(32'(cr));
    push("solid_g_high_count", 0);
    pop_check(32'(cg));
    push("solid_b_high_count", 255);
    pop_check(32'(cb));

    // BLINK red, period 2: phase every 8 clocks, duty sampled at wrap
    send(2, 24'hFF0000, 2);
    repeat (700) step();

    // BREATHE blue, period 0 (treated as 1): full rise and fall
    send(3, 24'h0000FF, 0);
    repeat (2300) step();

    // OFF from RUN, then a redundant OFF
    send(0, 24'h000000, 0);
    repeat (20) step();
    send(0, 24'h123456, 3);
    repeat (20) step();

    // Request held across power-up is taken on the first RUN cycle
    send(1, 24'h000010, 1);
    cfg_valid  = 1'b1;
    cfg_mode   = 2'd2;
    cfg_color  = 24'h00FF00;
    cfg_period = 8'd1;
    guard      = 0;
    was_ready  = 1'b0;
    do begin
      was_ready = (cfg_ready === 1'b1);
      step();
      guard++;
    end while (!was_ready && guard < 50);
    cfg_valid = 1'b0;
    push("held_request_accepted", 1);
    pop_check(32'(was_ready));
    repeat (600) step();

    // Asynchronous reset in the middle of the blink pattern
    #3 rst = 1'b1;
    #1 check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
